// File: rtl/vr_loc_scan.sv
// rtl/vr_loc_scan.sv - round-robin pot scanner: settle, average and hysteresis-filter detector location per channel
module vr_loc_scan #(
    parameter int C_CH_N     = 4,
    parameter int C_SEL_W    = 2,
    parameter int C_SETTLE   = 1048576,
    parameter int C_SETTLE_W = 21,
    parameter int C_AVG_SH   = 2,
    parameter int C_HYS      = 2
) (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic               EN_CK_i,
    input  logic               RUN_i,
    input  logic [7:0]         LOC_i,
    output logic [C_SEL_W-1:0] SEL_o,
    output logic               BUSY_o,
    input  logic [C_SEL_W-1:0] RD_ADR_i,
    output logic [7:0]         RD_DAT_o,
    output logic [C_CH_N-1:0]  VLD_o,
    output logic               UPD_o,
    output logic [C_SEL_W-1:0] UPD_CH_o,
    output logic [7:0]         UPD_DAT_o,
    output logic               CHG_o
);

    localparam int ACC_W = 8 + C_AVG_SH;
    localparam int SMP_W = C_AVG_SH + 1;
    localparam logic [SMP_W-1:0]      SMP_LAST = SMP_W'((1 << C_AVG_SH) - 1);
    localparam logic [C_SEL_W-1:0]    CH_LAST  = C_SEL_W'(C_CH_N - 1);
    localparam logic [C_SEL_W:0]      CH_N_L   = (C_SEL_W + 1)'(C_CH_N);
    localparam logic [C_SETTLE_W-1:0] SET_INI  = C_SETTLE_W'(C_SETTLE - 1);
    localparam logic [7:0]            HYS_L    = 8'(C_HYS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETTLE,
        ST_ACC,
        ST_STORE
    } state_t;

    state_t                state_q, state_d;
    logic [C_SEL_W-1:0]    ch_q, ch_d;
    logic [C_SEL_W-1:0]    sel_q, sel_d;
    logic [C_SETTLE_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [SMP_W-1:0]      smp_q, smp_d;
    logic [7:0]            bank_q [C_CH_N];
    logic [7:0]            bank_d [C_CH_N];
    logic [C_CH_N-1:0]     vld_q, vld_d;
    logic                  busy_q, busy_d;
    logic [7:0]            rd_dat_q, rd_dat_d;
    logic                  upd_q, upd_d;
    logic [C_SEL_W-1:0]    upd_ch_q, upd_ch_d;
    logic [7:0]            upd_dat_q, upd_dat_d;
    logic                  chg_q, chg_d;

    logic [7:0] avg;
    logic [7:0] stored;
    logic [7:0] diff;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        smp_d     = smp_q;
        bank_d    = bank_q;
        vld_d     = vld_q;
        upd_d     = 1'b0;
        chg_d     = 1'b0;
        upd_ch_d  = upd_ch_q;
        upd_dat_d = upd_dat_q;

        avg    = acc_q[ACC_W-1:C_AVG_SH];
        stored = bank_q[ch_q];
        diff   = (avg >= stored) ? (avg - stored) : (stored - avg);

        if (EN_CK_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (RUN_i) state_d = ST_SEL;
                end
                ST_SEL: begin
                    if (!RUN_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel_d   = ch_q;
                        cnt_d   = SET_INI;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!RUN_i) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        acc_d   = '0;
                        smp_d   = '0;
                        state_d = ST_ACC;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_ACC: begin
                    if (!RUN_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = acc_q + ACC_W'(LOC_i);
                        smp_d = smp_q + 1'b1;
                        if (smp_q == SMP_LAST) state_d = ST_STORE;
                    end
                end
                ST_STORE: begin
                    // First measurement of a channel always lands, whatever the distance.
                    if (!vld_q[ch_q] || diff > HYS_L) begin
                        bank_d[ch_q] = avg;
                        vld_d[ch_q]  = 1'b1;
                        chg_d        = 1'b1;
                    end
                    upd_d     = 1'b1;
                    upd_ch_d  = ch_q;
                    upd_dat_d = avg;
                    ch_d      = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    state_d   = RUN_i ? ST_SEL : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d   = (state_q != ST_IDLE);
        rd_dat_d = 8'h80;
        if ({1'b0, RD_ADR_i} < CH_N_L) rd_dat_d = bank_q[RD_ADR_i];
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            smp_q     <= '0;
            for (int i = 0; i < C_CH_N; i++) bank_q[i] <= 8'h80;
            vld_q     <= '0;
            busy_q    <= 1'b0;
            rd_dat_q  <= 8'h80;
            upd_q     <= 1'b0;
            upd_ch_q  <= '0;
            upd_dat_q <= 8'h80;
            chg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            smp_q     <= smp_d;
            bank_q    <= bank_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            rd_dat_q  <= rd_dat_d;
            upd_q     <= upd_d;
            upd_ch_q  <= upd_ch_d;
            upd_dat_q <= upd_dat_d;
            chg_q     <= chg_d;
        end
    end

    assign SEL_o     = sel_q;
    assign BUSY_o    = busy_q;
    assign RD_DAT_o  = rd_dat_q;
    assign VLD_o     = vld_q;
    assign UPD_o     = upd_q;
    assign UPD_CH_o  = upd_ch_q;
    assign UPD_DAT_o = upd_dat_q;
    assign CHG_o     = chg_q;

endmodule
